// File: rtl/draw_square_move_ctl_if.sv
// VGA timing bundle shared between the timing generator and per-frame consumers.
interface vga_if #(
  parameter int unsigned W = 11
);
  logic [W-1:0] hcount;
  logic [W-1:0] vcount;

  modport master (output hcount, output vcount);
  modport slave  (input  hcount, input  vcount);
endinterface

// File: rtl/draw_square_move_ctl.sv
// Frame-synchronous square position controller: 4-way step moves with auto-repeat, home and window limits.
// Define SQUARE_WRAP_EN to wrap at the window edges instead of clamping.
module draw_square_move_ctl #(
  parameter int unsigned W          = 12,
  parameter int unsigned X_INIT     = 150,
  parameter int unsigned Y_INIT     = 100,
  parameter int unsigned STEP       = 8,
  parameter int unsigned SIZE       = 8,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 1023,
  parameter int unsigned Y_MIN      = 0,
  parameter int unsigned Y_MAX      = 767,
  parameter int unsigned REPEAT_DLY = 15,
  parameter int unsigned REPEAT_DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_if.slave         vga_in,
  input  logic [3:0]   move_req,
  input  logic         home,
  output logic [W-1:0] xpos_square,
  output logic [W-1:0] ypos_square,
  output logic [3:0]   at_edge,
  output logic         moving
);

  localparam logic [W-1:0] X_LO   = W'(X_MIN);
  localparam logic [W-1:0] X_HI   = W'(X_MAX - SIZE + 1);
  localparam logic [W-1:0] Y_LO   = W'(Y_MIN);
  localparam logic [W-1:0] Y_HI   = W'(Y_MAX - SIZE + 1);
  localparam logic [W-1:0] X_HOME = W'(X_INIT);
  localparam logic [W-1:0] Y_HOME = W'(Y_INIT);
  localparam logic signed [W:0] STEP_V = (W+1)'(STEP);

  localparam int unsigned  CW     = $clog2(REPEAT_DLY + REPEAT_DIV + 1);
  localparam logic [CW-1:0] DLY_LD = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] DIV_LD = CW'(REPEAT_DIV - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVE   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    req_lat_q, req_lat_d;
  logic          home_lat_q, home_lat_d;

  logic       frame_tick;
  logic [3:0] req_eff;
  logic       home_eff;
  logic       step_en;

  // One axis step in W+1 signed bits so a step below zero is caught before truncation.
  function automatic logic [W-1:0] step_axis(
    input logic [W-1:0] pos,
    input logic         inc,
    input logic         dec,
    input logic [W-1:0] lo,
    input logic [W-1:0] hi
  );
    logic signed [W:0] p;
    logic signed [W:0] n;
    p = $signed({1'b0, pos});
    if (inc)      n = p + STEP_V;
    else if (dec) n = p - STEP_V;
    else          n = p;
    step_axis = n[W-1:0];
    if (n < $signed({1'b0, lo}))      step_axis = lo;
    else if (n > $signed({1'b0, hi})) step_axis = hi;
`ifdef SQUARE_WRAP_EN
    if (inc && pos == hi) step_axis = lo;
    if (dec && pos == lo) step_axis = hi;
`endif
  endfunction

  always_comb begin
    frame_tick = (vga_in.hcount == '0) && (vga_in.vcount == '0);
    req_eff    = req_lat_q | move_req;
    home_eff   = home_lat_q | home;

    x_d        = x_q;
    y_d        = y_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_lat_d  = req_eff;
    home_lat_d = home_eff;
    step_en    = 1'b0;

    if (frame_tick) begin
      // Latches restart from this cycle's inputs so a request on the tick cycle also counts next frame.
      req_lat_d  = move_req;
      home_lat_d = home;
      if (home_eff) begin
        x_d     = X_HOME;
        y_d     = Y_HOME;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (req_eff == '0) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            step_en = 1'b1;
            cnt_d   = DLY_LD;
            state_d = ST_MOVE;
          end
          ST_MOVE: begin
            if (cnt_q == CW'(1)) begin
              state_d = ST_REPEAT;
              cnt_d   = DIV_LD;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          ST_REPEAT: begin
            if (cnt_q == '0) begin
              step_en = 1'b1;
              cnt_d   = DIV_LD;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    if (step_en) begin
      x_d = step_axis(x_q, req_eff[0] & ~req_eff[1], req_eff[1] & ~req_eff[0], X_LO, X_HI);
      y_d = step_axis(y_q, req_eff[2] & ~req_eff[3], req_eff[3] & ~req_eff[2], Y_LO, Y_HI);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= X_HOME;
      y_q        <= Y_HOME;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_lat_q  <= '0;
      home_lat_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_lat_q  <= req_lat_d;
      home_lat_q <= home_lat_d;
    end
  end

  assign xpos_square = x_q;
  assign ypos_square = y_q;
  assign moving      = (state_q != ST_IDLE);
  assign at_edge     = {y_q == Y_LO, y_q == Y_HI, x_q == X_LO, x_q == X_HI};

endmodule

// File: tb/tb_draw_square_move_ctl.sv
// Self-checking bench for draw_square_move_ctl: vector table, corner sequences, random run vs frame-level model.
module tb_draw_square_move_ctl;

  localparam int X_INIT = 150;
  localparam int Y_INIT = 100;
  localparam int STEP   = 8;
  localparam int XHI    = 1023 - 8 + 1;
  localparam int YHI    = 767 - 8 + 1;
  localparam int DLY    = 15;
  localparam int DIV    = 2;
  localparam int H      = 8;
  localparam int V      = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  move_req;
  logic        home;
  logic [11:0] xpos, ypos;
  logic [3:0]  at_edge;
  logic        moving;

  always #5 clk = ~clk;

  vga_if #(.W(11)) vga ();

  draw_square_move_ctl #(
    .W(12), .X_INIT(150), .Y_INIT(100), .STEP(8), .SIZE(8),
    .X_MIN(0), .X_MAX(1023), .Y_MIN(0), .Y_MAX(767),
    .REPEAT_DLY(15), .REPEAT_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga), .move_req(move_req), .home(home),
    .xpos_square(xpos), .ypos_square(ypos), .at_edge(at_edge), .moving(moving)
  );

  int n_cmp = 0;
  int n_err = 0;
  int hc, vc;
  int mx, my, hold;
  logic [3:0] lat_req;
  logic       lat_home;
  bit         chk_pending;

  typedef struct {
    logic [3:0] req;
    logic       hm;
    int         frames;
    int         ex;
    int         ey;
    logic [3:0] exp_edge;
    logic       mv;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mstep(input int p, input int d, input int lo, input int hi);
    int n;
    if (d == 0) return p;
`ifdef SQUARE_WRAP_EN
    if (d > 0 && p == hi) return lo;
    if (d < 0 && p == lo) return hi;
`endif
    n = p + d * STEP;
    if (n < lo) n = lo;
    if (n > hi) n = hi;
    return n;
  endfunction

  function automatic logic [3:0] medge();
    return {my == 0, my == YHI, mx == 0, mx == XHI};
  endfunction

  // Reference: count consecutive active ticks; step on the first, then every DIV ticks after DLY idle ones.
  task automatic model_tick(input logic [3:0] r, input logic h);
    int dx, dy;
    dx = (r[0] && !r[1]) ? 1 : ((r[1] && !r[0]) ? -1 : 0);
    dy = (r[2] && !r[3]) ? 1 : ((r[3] && !r[2]) ? -1 : 0);
    if (h) begin
      mx = X_INIT; my = Y_INIT; hold = 0;
    end else if (r != 4'b0) begin
      hold++;
      if (hold == 1 || (hold > DLY + 1 && (hold - DLY - 1) % DIV == 0)) begin
        mx = mstep(mx, dx, 0, XHI);
        my = mstep(my, dy, 0, YHI);
      end
    end else begin
      hold = 0;
    end
  endtask

  task automatic check_model();
    chk("model x", int'(xpos), mx);
    chk("model y", int'(ypos), my);
    chk("model at_edge", int'(at_edge), int'(medge()));
    chk("model moving", int'(moving), int'(hold > 0));
  endtask

  task automatic model_reset();
    mx = X_INIT; my = Y_INIT; hold = 0;
    lat_req = '0; lat_home = 1'b0; chk_pending = 1'b0;
  endtask

  task automatic cyc(input logic [3:0] r, input logic h);
    @(negedge clk);
    if (chk_pending) begin
      check_model();
      chk_pending = 1'b0;
    end
    move_req   = r;
    home       = h;
    vga.hcount = 11'(hc);
    vga.vcount = 11'(vc);
    if (hc == 0 && vc == 0) begin
      model_tick(lat_req | r, lat_home | h);
      lat_req     = r;
      lat_home    = h;
      chk_pending = 1'b1;
    end else begin
      lat_req  = lat_req | r;
      lat_home = lat_home | h;
    end
    hc++;
    if (hc == H) begin
      hc = 0;
      vc = (vc == V - 1) ? 0 : vc + 1;
    end
  endtask

  // Holds r/h during the frame but drives idle on tick cycles, so each run of frames stands alone.
  task automatic run_frames(input logic [3:0] r, input logic h, input int n);
    int t = 0;
    while (t < n) begin
      if (hc == 0 && vc == 0) begin
        cyc(4'b0, 1'b0);
        t++;
      end else begin
        cyc(r, h);
      end
    end
  endtask

  task automatic settle();
    cyc(4'b0, 1'b0);
  endtask

  task automatic expect_pos(input string tag, input int ex, input int ey, input int ee, input int mv);
    chk({tag, " x"}, int'(xpos), ex);
    chk({tag, " y"}, int'(ypos), ey);
    chk({tag, " at_edge"}, int'(at_edge), ee);
    chk({tag, " moving"}, int'(moving), mv);
  endtask

  task automatic do_reset(input string tag);
    vga.hcount = 11'd1;
    vga.vcount = 11'd0;
    rst_n = 1'b0;
    #1;
    expect_pos(tag, X_INIT, Y_INIT, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hc = 2; vc = 0;
  endtask

  initial begin
    int guard;
    logic [3:0] cur;
    logic [3:0] dirs[8];

    tbl[0]  = '{4'b0001, 1'b0,  1, 158, 100, 4'b0000, 1'b1};
    tbl[1]  = '{4'b0001, 1'b0, 15, 158, 100, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0001, 1'b0,  1, 158, 100, 4'b0000, 1'b1};
    tbl[3]  = '{4'b0001, 1'b0,  1, 166, 100, 4'b0000, 1'b1};
    tbl[4]  = '{4'b0001, 1'b0,  2, 174, 100, 4'b0000, 1'b1};
    tbl[5]  = '{4'b0001, 1'b0,  4, 190, 100, 4'b0000, 1'b1};
    tbl[6]  = '{4'b0000, 1'b0,  1, 190, 100, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0111, 1'b0,  1, 190, 108, 4'b0000, 1'b1};
    tbl[8]  = '{4'b0111, 1'b0, 15, 190, 108, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0111, 1'b0,  2, 190, 116, 4'b0000, 1'b1};
    tbl[10] = '{4'b0000, 1'b0,  1, 190, 116, 4'b0000, 1'b0};
    tbl[11] = '{4'b1000, 1'b0,  1, 190, 108, 4'b0000, 1'b1};
    tbl[12] = '{4'b0000, 1'b0,  1, 190, 108, 4'b0000, 1'b0};
    tbl[13] = '{4'b0000, 1'b1,  1, 150, 100, 4'b0000, 1'b0};

    rst_n = 1'b1; move_req = '0; home = 1'b0;
    vga.hcount = 11'd5; vga.vcount = 11'd0;
    hc = 5; vc = 0;
    model_reset();
    #2;
    do_reset("reset");

    for (int i = 0; i < 14; i++) begin
      run_frames(tbl[i].req, tbl[i].hm, tbl[i].frames);
      settle();
      expect_pos($sformatf("row%0d", i), tbl[i].ex, tbl[i].ey, int'(tbl[i].exp_edge), int'(tbl[i].mv));
    end

    // Single-clock pulse mid-frame must survive until the tick.
    cyc(4'b0001, 1'b0);
    run_frames(4'b0, 1'b0, 1);
    settle();
    expect_pos("pulse", 158, 100, 0, 1);
    run_frames(4'b0, 1'b0, 1);
    settle();
    expect_pos("pulse idle", 158, 100, 0, 0);

    // Hold right into the window edge.
    guard = 0;
    while (guard < 250 && xpos != 12'(XHI)) begin
      run_frames(4'b0001, 1'b0, 1);
      settle();
      guard++;
    end
    chk("edge x", int'(xpos), XHI);
    chk("edge at_edge", int'(at_edge), 1);
`ifdef SQUARE_WRAP_EN
    guard = 0;
    while (guard < 4 && xpos == 12'(XHI)) begin
      run_frames(4'b0001, 1'b0, 1);
      settle();
      guard++;
    end
    chk("wrap x", int'(xpos), 0);
    chk("wrap at_edge", int'(at_edge), 2);
`else
    run_frames(4'b0001, 1'b0, 4);
    settle();
    chk("clamp x", int'(xpos), XHI);
    chk("clamp at_edge", int'(at_edge), 1);
`endif
    run_frames(4'b0, 1'b0, 1);
    settle();

    // Home pulse during auto-repeat, then reset during auto-repeat.
    run_frames(4'b0, 1'b1, 1);
    settle();
    run_frames(4'b0001, 1'b0, 20);
    settle();
    chk("repeat moving", int'(moving), 1);
    cyc(4'b0001, 1'b1);
    run_frames(4'b0001, 1'b0, 1);
    settle();
    expect_pos("home", X_INIT, Y_INIT, 0, 0);
    run_frames(4'b0001, 1'b0, 20);
    settle();
    @(negedge clk);
    do_reset("reset in repeat");

    dirs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b1010, 4'b0011, 4'b0000};
    cur = 4'b0001;
    for (int i = 0; i < H * V * 600; i++) begin
      if ($urandom_range(0, 599) == 0) cur = dirs[$urandom_range(0, 7)];
      if ($urandom_range(0, 99) == 0)  cur = cur ^ 4'($urandom_range(0, 15));
      cyc(cur, $urandom_range(0, 2999) == 0);
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
